// File: rtl/seq_scan_pkg.sv
// Shared definitions for the word-level scan controller and its serial pattern detector.
package seq_scan_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_PAT_W  = 4;
    localparam int DEF_CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/seq_pattern_det.sv
// Bit-serial pattern detector: shift history plus Mealy compare against the programmed pattern.
module seq_pattern_det #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic [PAT_W-1:0] pattern,
    output logic             match
);

    localparam int FILL_W = $clog2(PAT_W) + 1;

    logic [PAT_W-1:0]  hist_reg;
    logic [PAT_W-1:0]  hist_next;
    logic [FILL_W-1:0] fill_reg;

    assign hist_next = {hist_reg[PAT_W-2:0], bit_in};

    // fill_reg counts consumed bits, saturating once the history is full enough to match
    assign match = bit_valid && (fill_reg >= FILL_W'(PAT_W - 1)) && (hist_next == pattern);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (clear) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else if (bit_valid) begin
            hist_reg <= hist_next;
            if (fill_reg < FILL_W'(PAT_W - 1))
                fill_reg <= fill_reg + FILL_W'(1);
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// One-shot word scanner: latches a word and pattern on start, streams the word MSB-first
// through the serial detector, and reports match count, found flag and first match position.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int PAT_W  = DEF_PAT_W,
    parameter int CNT_W  = DEF_CNT_W,
    localparam int IDX_W = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] data_in,
    input  logic [PAT_W-1:0]  pattern,
    output logic              busy,
    output logic              done,
    output logic              bit_out,
    output logic              bit_valid,
    output logic [CNT_W-1:0]  match_count,
    output logic              found,
    output logic [IDX_W-1:0]  first_pos
);

    scan_state_t       state_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic [IDX_W-1:0]  bit_idx_reg;
    logic [CNT_W-1:0]  match_count_reg;
    logic              found_reg;
    logic [IDX_W-1:0]  first_pos_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              bit_valid_reg;

    logic det_clear;
    logic det_valid;
    logic det_match;

    assign det_clear = (state_reg == ST_IDLE) && start;
    // an aborted cycle's bit never reaches the detector
    assign det_valid = (state_reg == ST_SHIFT) && !abort;

    seq_pattern_det #(
        .PAT_W(PAT_W)
    ) u_det (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (det_clear),
        .bit_in   (shift_reg[DATA_W-1]),
        .bit_valid(det_valid),
        .pattern  (pat_reg),
        .match    (det_match)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_IDLE;
            shift_reg       <= '0;
            pat_reg         <= '0;
            bit_idx_reg     <= '0;
            match_count_reg <= '0;
            found_reg       <= 1'b0;
            first_pos_reg   <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            bit_valid_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        shift_reg       <= data_in;
                        pat_reg         <= pattern;
                        bit_idx_reg     <= '0;
                        match_count_reg <= '0;
                        found_reg       <= 1'b0;
                        first_pos_reg   <= '0;
                        busy_reg        <= 1'b1;
                        bit_valid_reg   <= 1'b1;
                        state_reg       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        match_count_reg <= '0;
                        found_reg       <= 1'b0;
                        first_pos_reg   <= '0;
                        busy_reg        <= 1'b0;
                        bit_valid_reg   <= 1'b0;
                        state_reg       <= ST_IDLE;
                    end else begin
                        shift_reg   <= {shift_reg[DATA_W-2:0], 1'b0};
                        bit_idx_reg <= bit_idx_reg + IDX_W'(1);
                        if (det_match) begin
                            if (match_count_reg != {CNT_W{1'b1}})
                                match_count_reg <= match_count_reg + CNT_W'(1);
                            if (!found_reg) begin
                                found_reg     <= 1'b1;
                                first_pos_reg <= bit_idx_reg;
                            end
                        end
                        if (bit_idx_reg == IDX_W'(DATA_W - 1)) begin
                            bit_valid_reg <= 1'b0;
                            done_reg      <= 1'b1;
                            state_reg     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg      <= 1'b0;
                    done_reg      <= 1'b0;
                    bit_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign bit_valid   = bit_valid_reg;
    assign bit_out     = bit_valid_reg && shift_reg[DATA_W-1];
    assign match_count = match_count_reg;
    assign found       = found_reg;
    assign first_pos   = first_pos_reg;

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scan controller for the serial sequence detector. It accepts a parallel data word and a programmable bit pattern through a start/done handshake, then shifts the word MSB-first through an embedded pattern detector, one bit per clock. It reports the match count, whether any match occurred, and the position of the first match. It lets a host treat the bit-serial detector as a one-shot, word-level resource.

## Interface
- DATA_W, 16, width of the scanned word; must be ≥ PAT_W
- PAT_W, 4, pattern length in bits; must be ≥ 2
- CNT_W, 5, width of match_count; saturates at 2^CNT_W−1
- IDX_W (localparam), $clog2(DATA_W), width of first_pos

Ports:
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request a scan; sampled only in IDLE
- abort  in  1  cancel a scan in progress; sampled only in SHIFT
- data_in  in  DATA_W  word to scan; latched when start is accepted
- pattern  in  PAT_W  pattern to detect; pattern[PAT_W−1] is the first bit in time; latched when start is accepted
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse when a scan completes
- bit_out  out  1  bit currently presented to the detector (monitor)
- bit_valid  out  1  high while bit_out is being consumed
- match_count  out  CNT_W  number of matches, overlapping matches included
- found  out  1  at least one match
- first_pos  out  IDX_W  bit index (0 = MSB) of the last bit of the first match

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding constants live in the package.
- IDLE:
  - If start=1: latch data_in into shift_reg and pattern into pat_reg.
  - Clear bit_idx, match_count, found, first_pos and the detector history.
  - Go to SHIFT.
- SHIFT: each cycle:
  - bit_out = shift_reg[DATA_W−1] and bit_valid = 1.
  - The detector consumes the bit.
  - shift_reg shifts left with zero fill; bit_idx increments.
  - When bit_idx = DATA_W−1 (last bit), go to DONE.
- Abort in SHIFT:
  - abort=1 takes priority over normal shifting. The bit in that cycle is not consumed.
  - Go to IDLE with no done pulse.
  - Clear match_count, found and first_pos.
- DONE: assert done for one cycle, then go to IDLE.
- start while busy is ignored and not queued.
- Detector (sub-module):
  - PAT_W-bit history register: hist_next = {hist[PAT_W−2:0], bit}.
  - The match is Mealy: match = bit_valid & (bits_seen ≥ PAT_W−1) & (hist_next == pat_reg), where bits_seen counts bits already consumed in this scan.
  - Matches may overlap; the history is not cleared after a match.
- On each match:
  - match_count increments, saturating at 2^CNT_W−1.
  - If found=0: set found=1 and first_pos = bit_idx.
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - Every output is 0: busy, done, bit_out, bit_valid, match_count, found, first_pos.
  - Internal registers clear.
  - Reset mid-scan discards the scan with no done pulse.

## Timing
- start accepted at edge E0 → SHIFT during cycles E0..E0+DATA_W−1 (DATA_W bits) → DONE during the cycle after edge E0+DATA_W, with done=1 → IDLE after edge E0+DATA_W+1.
- Latency from start acceptance to done: DATA_W+1 cycles.
- Minimum start-to-start spacing: DATA_W+2 cycles.
- match_count, found and first_pos update on the edge that ends the match cycle.
  - They are final and valid when done=1.
  - They hold until the next accepted start or until abort.
- busy rises on the edge after start is accepted and falls on the edge where DONE exits.
- A start asserted in the same cycle done is high is ignored, because the FSM is in DONE, not IDLE.

## Structure
- Package seq_scan_pkg holds:
  - state encoding constants (IDLE, SHIFT, DONE)
  - default parameter values
- Sub-module seq_pattern_det (parameter PAT_W). It contains the history register and the match compare, with inputs bit_in, bit_valid, clear and pattern, and output match.
  - The controller owns the FSM, shift register, bit index, counters and handshake.

## Test plan
- DATA_W=16, PAT_W=4, pattern=4'b1110, data=16'hE0E0 → done exactly 17 cycles after start; match_count=2, found=1, first_pos=3.
- pattern=4'b1111, data=16'hFFFF → match_count=13 (overlapping); first_pos=3. Repeat with CNT_W=3 → match_count saturates at 7.
- data=16'h0000, pattern=4'b1110 → match_count=0, found=0, first_pos=0; done still pulses once.
- Abort on the 5th SHIFT cycle with data=16'hE0E0 → no done pulse; busy low the next cycle; match_count=0, found=0. An immediately following start runs a full scan correctly.
- start held high throughout a scan of 16'hE0E0 → a second scan begins only after DONE; the first done shows match_count=2.
- reset_n low mid-scan → all outputs 0 asynchronously. After release, with no start, the FSM stays in IDLE and no done pulse occurs.
